sram_bridge: RTL and testbench

- Responder-side memory controller that services the CPU's 32-bit load/store requests against the board's external asynchronous 16-bit SRAM.
- Accepts one request at a time over a req/busy/done handshake.
- Splits each request into up to two halfword SRAM cycles: low half first, then high half.
- Drives the SRAM strobes with setup/access/hold timing and returns assembled read data.

---
 rtl/sram_bridge_pkg.sv | 30 +++
 rtl/sram_wait_timer.sv | 26 ++
 rtl/sram_bridge.sv | 163 ++++++++++++++++
 tb/tb_sram_bridge.sv | 196 +++++++++++++++++++
 4 files changed

// File: rtl/sram_bridge_pkg.sv
// Shared types and constants for the 32-bit CPU to 16-bit asynchronous SRAM bridge.
package sram_bridge_pkg;

   localparam int HALF_W = 16;
   localparam int WORD_W = 32;
   localparam int BE_W   = 4;

   localparam logic LO_HALF = 1'b0;
   localparam logic HI_HALF = 1'b1;

   typedef enum logic [2:0] {
      IDLE,
      LO_ACC,
      LO_HOLD,
      HI_ACC,
      HI_HOLD,
      RESP
   } state_t;

   // Expands byte enables into a per-bit mask so disabled bytes read back as zero.
   function automatic logic [WORD_W-1:0] be_mask(input logic [BE_W-1:0] be);
      logic [WORD_W-1:0] m;
      m = '0;
      for (int i = 0; i < BE_W; i++) begin
         m[i*8 +: 8] = {8{be[i]}};
      end
      return m;
   endfunction

endpackage

// File: rtl/sram_wait_timer.sv
// Loadable down-counter that flags the final cycle of an SRAM access phase.
module sram_wait_timer #(
   parameter int CNT_W = 4
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             load,
   input  logic [CNT_W-1:0] load_val,
   output logic             last_cycle
);

   logic [CNT_W-1:0] cnt;

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         cnt <= '0;
      end else if (load) begin
         cnt <= load_val;
      end else if (cnt != '0) begin
         cnt <= cnt - 1'b1;
      end
   end

   assign last_cycle = (cnt == '0);

endmodule

// File: rtl/sram_bridge.sv
// CPU word load/store to 16-bit async SRAM bridge: low half then high half, each access+hold.
// Define SRAM_BRIDGE_HEXTAP_EN to register the last completed transaction's data on dbg_last.
module sram_bridge
   import sram_bridge_pkg::*;
#(
   parameter int WAIT_CYCLES = 1,
   parameter int WORD_ADDR_W = 19
) (
   input  logic                   clock,
   input  logic                   reset,
   input  logic                   cpu_req,
   input  logic                   cpu_we,
   input  logic [WORD_ADDR_W-1:0] cpu_addr,
   input  logic [WORD_W-1:0]      cpu_wdata,
   input  logic [BE_W-1:0]        cpu_be,
   output logic                   cpu_busy,
   output logic                   cpu_done,
   output logic [WORD_W-1:0]      cpu_rdata,
   output logic [WORD_ADDR_W:0]   sram_addr,
   inout  wire  [HALF_W-1:0]      sram_dq,
   output logic                   sram_we_n,
   output logic                   sram_oe_n,
   output logic                   sram_ce_n,
   output logic                   sram_ub_n,
   output logic                   sram_lb_n,
   output logic [WORD_W-1:0]      dbg_last
);

   localparam logic [3:0] WAIT_LOAD = 4'(WAIT_CYCLES - 1);

   state_t                 state, next_state;
   logic                   we_q;
   logic [WORD_ADDR_W-1:0] addr_q;
   logic [WORD_W-1:0]      wdata_q;
   logic [BE_W-1:0]        be_q;
   logic [WORD_W-1:0]      rd_buf;
   logic                   last_cycle, timer_load;
   logic                   in_lo, in_hi, in_acc, drive;
   logic [HALF_W-1:0]      wdata_half;
   logic                   fin_hold, fin_zero;

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state <= IDLE;
      end else begin
         state <= next_state;
      end
   end

   always_comb begin
      next_state = state;
      case (state)
         IDLE: begin
            if (cpu_req) begin
               if (|cpu_be[1:0])      next_state = LO_ACC;
               else if (|cpu_be[3:2]) next_state = HI_ACC;
               else                   next_state = RESP;
            end
         end
         LO_ACC:  if (last_cycle) next_state = LO_HOLD;
         LO_HOLD: next_state = (|be_q[3:2]) ? HI_ACC : RESP;
         HI_ACC:  if (last_cycle) next_state = HI_HOLD;
         HI_HOLD: next_state = RESP;
         RESP:    next_state = IDLE;
         default: next_state = IDLE;
      endcase
   end

   assign timer_load = ((next_state == LO_ACC) && (state != LO_ACC)) ||
                       ((next_state == HI_ACC) && (state != HI_ACC));

   sram_wait_timer #(.CNT_W(4)) u_timer (
      .clock      (clock),
      .reset      (reset),
      .load       (timer_load),
      .load_val   (WAIT_LOAD),
      .last_cycle (last_cycle)
   );

   assign in_lo  = (state == LO_ACC) || (state == LO_HOLD);
   assign in_hi  = (state == HI_ACC) || (state == HI_HOLD);
   assign in_acc = (state == LO_ACC) || (state == HI_ACC);

   // Strobes decode straight from state so an async reset releases the bus at once.
   always_comb begin
      sram_we_n  = 1'b1;
      sram_oe_n  = 1'b1;
      sram_ce_n  = 1'b1;
      sram_lb_n  = 1'b1;
      sram_ub_n  = 1'b1;
      sram_addr  = '0;
      drive      = 1'b0;
      wdata_half = in_hi ? wdata_q[31:16] : wdata_q[15:0];
      if (in_lo || in_hi) begin
         sram_ce_n = 1'b0;
         sram_addr = {addr_q, (in_hi ? HI_HALF : LO_HALF)};
         sram_lb_n = ~(in_hi ? be_q[2] : be_q[0]);
         sram_ub_n = ~(in_hi ? be_q[3] : be_q[1]);
         drive     = we_q;
         if (in_acc) begin
            sram_we_n = ~we_q;
            sram_oe_n = we_q;
         end
      end
   end

   assign sram_dq = drive ? wdata_half : {HALF_W{1'bz}};

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         we_q    <= 1'b0;
         addr_q  <= '0;
         wdata_q <= '0;
         be_q    <= '0;
         rd_buf  <= '0;
      end else begin
         if (state == IDLE && cpu_req) begin
            we_q    <= cpu_we;
            addr_q  <= cpu_addr;
            wdata_q <= cpu_wdata;
            be_q    <= cpu_be;
         end
         if (state == LO_ACC && last_cycle && !we_q) rd_buf[15:0]  <= sram_dq;
         if (state == HI_ACC && last_cycle && !we_q) rd_buf[31:16] <= sram_dq;
      end
   end

   // Response data is loaded on the edge into RESP so it is valid alongside cpu_done.
   assign fin_hold = ((state == LO_HOLD) || (state == HI_HOLD)) && (next_state == RESP);
   assign fin_zero = (state == IDLE) && (next_state == RESP);

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         cpu_rdata <= '0;
      end else if (fin_zero && !cpu_we) begin
         cpu_rdata <= '0;
      end else if (fin_hold && !we_q) begin
         cpu_rdata <= rd_buf & be_mask(be_q);
      end
   end

   assign cpu_busy = (state != IDLE);
   assign cpu_done = (state == RESP);

`ifdef SRAM_BRIDGE_HEXTAP_EN
   logic [WORD_W-1:0] dbg_q;

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         dbg_q <= '0;
      end else if (fin_zero) begin
         dbg_q <= '0;
      end else if (fin_hold) begin
         dbg_q <= (we_q ? wdata_q : rd_buf) & be_mask(be_q);
      end
   end

   assign dbg_last = dbg_q;
`else
   assign dbg_last = '0;
`endif

endmodule

// File: tb/tb_sram_bridge.sv
// Directed bench for sram_bridge with a byte-lane SRAM model and strobe activity counters.
module tb_sram_bridge;

   logic        clock = 1'b0;
   logic        reset = 1'b1;
   logic        cpu_req = 1'b0;
   logic        cpu_we = 1'b0;
   logic [18:0] cpu_addr = '0;
   logic [31:0] cpu_wdata = '0;
   logic [3:0]  cpu_be = '0;
   logic        cpu_busy, cpu_done;
   logic [31:0] cpu_rdata, dbg_last;
   logic [19:0] sram_addr;
   wire  [15:0] sram_dq;
   logic        sram_we_n, sram_oe_n, sram_ce_n, sram_ub_n, sram_lb_n;

   logic [15:0] mem [0:255];

   int n_cmp = 0;
   int n_bad = 0;

   int we_cnt = 0, oe_cnt = 0, ce_cnt = 0, lb_cnt = 0, ub_cnt = 0, hi_cnt = 0, clash_cnt = 0;

   always #5 clock = ~clock;

   sram_bridge #(.WAIT_CYCLES(1), .WORD_ADDR_W(19)) dut (
      .clock     (clock),
      .reset     (reset),
      .cpu_req   (cpu_req),
      .cpu_we    (cpu_we),
      .cpu_addr  (cpu_addr),
      .cpu_wdata (cpu_wdata),
      .cpu_be    (cpu_be),
      .cpu_busy  (cpu_busy),
      .cpu_done  (cpu_done),
      .cpu_rdata (cpu_rdata),
      .sram_addr (sram_addr),
      .sram_dq   (sram_dq),
      .sram_we_n (sram_we_n),
      .sram_oe_n (sram_oe_n),
      .sram_ce_n (sram_ce_n),
      .sram_ub_n (sram_ub_n),
      .sram_lb_n (sram_lb_n),
      .dbg_last  (dbg_last)
   );

   // Asynchronous SRAM: drives on read, latches enabled byte lanes at the clock edge while we_n is low.
   assign sram_dq = (!sram_ce_n && !sram_oe_n && sram_we_n) ? mem[sram_addr[7:0]] : 16'bz;

   always @(posedge clock) begin
      if (!sram_ce_n && !sram_we_n) begin
         if (!sram_lb_n) mem[sram_addr[7:0]][7:0]  <= sram_dq[7:0];
         if (!sram_ub_n) mem[sram_addr[7:0]][15:8] <= sram_dq[15:8];
      end
   end

   always @(negedge clock) begin
      if (!reset) begin
         if (!sram_we_n) we_cnt++;
         if (!sram_oe_n) oe_cnt++;
         if (!sram_ce_n) ce_cnt++;
         if (!sram_lb_n) lb_cnt++;
         if (!sram_ub_n) ub_cnt++;
         if (!sram_ce_n && sram_addr[0]) hi_cnt++;
         if (!sram_oe_n && !sram_we_n) clash_cnt++;
      end
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
      end
   endtask

   task automatic run_req(input logic we, input logic [18:0] a, input logic [31:0] wd,
                          input logic [3:0] be, output logic [31:0] rd,
                          output int lat, output int busy_cyc);
      @(negedge clock);
      cpu_req = 1'b1; cpu_we = we; cpu_addr = a; cpu_wdata = wd; cpu_be = be;
      @(posedge clock);
      #1;
      cpu_req = 1'b0; cpu_we = ~we; cpu_addr = ~a; cpu_wdata = ~wd; cpu_be = ~be;
      lat = 0;
      busy_cyc = 0;
      while (lat < 50) begin
         @(negedge clock);
         lat++;
         if (cpu_busy) busy_cyc++;
         if (cpu_done) break;
      end
      rd = cpu_rdata;
   endtask

   initial begin
      logic [31:0] rd;
      int lat, busy, we0, oe0, ce0, lb0, ub0, hi0, cl0, wait_n, done_seen;

      for (int i = 0; i < 256; i++) mem[i] = 16'h0000;

      #12;
      chk("rst_busy", {31'b0, cpu_busy}, 32'd0);
      chk("rst_done", {31'b0, cpu_done}, 32'd0);
      chk("rst_rdata", cpu_rdata, 32'h0);
      chk("rst_strobes", {27'b0, sram_we_n, sram_oe_n, sram_ce_n, sram_ub_n, sram_lb_n}, 32'h1F);
      chk("rst_addr", {12'b0, sram_addr}, 32'h0);
      chk("rst_dbg", dbg_last, 32'h0);
      @(negedge clock);
      reset = 1'b0;

      // Full-word write
      we0 = we_cnt; cl0 = clash_cnt;
      run_req(1'b1, 19'h00010, 32'hDEADBEEF, 4'hF, rd, lat, busy);
      chk("wr_lat", lat, 32'd5);
      chk("wr_mem_lo", {16'b0, mem[8'h20]}, 32'h0000BEEF);
      chk("wr_mem_hi", {16'b0, mem[8'h21]}, 32'h0000DEAD);
      chk("wr_we_cycles", we_cnt - we0, 32'd2);
      chk("wr_clash", clash_cnt - cl0, 32'd0);

      // Full-word read back
      we0 = we_cnt; oe0 = oe_cnt; cl0 = clash_cnt;
      run_req(1'b0, 19'h00010, 32'h0, 4'hF, rd, lat, busy);
      chk("rd_data", rd, 32'hDEADBEEF);
      chk("rd_lat", lat, 32'd5);
      chk("rd_oe_cycles", oe_cnt - oe0, 32'd2);
      chk("rd_we_cycles", we_cnt - we0, 32'd0);
      chk("rd_clash", clash_cnt - cl0, 32'd0);
`ifdef SRAM_BRIDGE_HEXTAP_EN
      chk("dbg_after_rd", dbg_last, 32'hDEADBEEF);
`else
      chk("dbg_after_rd", dbg_last, 32'h0);
`endif

      // Single-byte write in the low half, upper byte lane only
      lb0 = lb_cnt; ub0 = ub_cnt; hi0 = hi_cnt;
      run_req(1'b1, 19'h00010, 32'h11223344, 4'h2, rd, lat, busy);
      chk("be2_lat", lat, 32'd3);
      chk("be2_mem_lo", {16'b0, mem[8'h20]}, 32'h000033EF);
      chk("be2_mem_hi", {16'b0, mem[8'h21]}, 32'h0000DEAD);
      chk("be2_lb_cycles", lb_cnt - lb0, 32'd0);
      chk("be2_ub_cycles", ub_cnt - ub0, 32'd2);
      chk("be2_hi_cycles", hi_cnt - hi0, 32'd0);

      // Partial read across both halves: disabled bytes return zero
      run_req(1'b0, 19'h00010, 32'h0, 4'h6, rd, lat, busy);
      chk("be6_data", rd, 32'h00AD3300);
      chk("be6_lat", lat, 32'd5);

      // Empty byte-enable read: immediate completion, no bus activity
      ce0 = ce_cnt;
      run_req(1'b0, 19'h00010, 32'h0, 4'h0, rd, lat, busy);
      chk("be0_lat", lat, 32'd1);
      chk("be0_data", rd, 32'h0);
      chk("be0_busy", busy, 32'd1);
      chk("be0_ce_cycles", ce_cnt - ce0, 32'd0);

      // Reset during the high-half access of a write
      @(negedge clock);
      cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 19'h00020; cpu_wdata = 32'hCAFEF00D; cpu_be = 4'hF;
      @(posedge clock);
      #1;
      cpu_req = 1'b0;
      wait_n = 0;
      while (wait_n < 20) begin
         @(negedge clock);
         wait_n++;
         if (sram_addr[0] && !sram_we_n) break;
      end
      chk("abort_reach_hi", wait_n, 32'd3);
      #1;
      reset = 1'b1;
      #1;
      chk("abort_strobes", {27'b0, sram_we_n, sram_oe_n, sram_ce_n, sram_ub_n, sram_lb_n}, 32'h1F);
      chk("abort_busy", {31'b0, cpu_busy}, 32'd0);
      chk("abort_done", {31'b0, cpu_done}, 32'd0);
      repeat (2) @(negedge clock);
      reset = 1'b0;
      done_seen = 0;
      repeat (5) begin
         @(negedge clock);
         if (cpu_done) done_seen++;
      end
      chk("abort_no_done", done_seen, 32'd0);
      chk("abort_mem_lo", {16'b0, mem[8'h40]}, 32'h0000F00D);
      chk("abort_mem_hi", {16'b0, mem[8'h41]}, 32'h0);

      run_req(1'b0, 19'h00020, 32'h0, 4'h3, rd, lat, busy);
      chk("post_abort_data", rd, 32'h0000F00D);
      chk("post_abort_lat", lat, 32'd3);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
